// File: rtl/trap_ctrl_pkg.sv
// Shared constants and types for the decode-stage trap sequencer:
// CSR addresses, cause codes, mstatus bit positions and FSM encodings.
package trap_ctrl_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CSR_AW = 12;

  localparam logic [CSR_AW-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [CSR_AW-1:0] CSR_MTVEC   = 12'h305;
  localparam logic [CSR_AW-1:0] CSR_MEPC    = 12'h341;
  localparam logic [CSR_AW-1:0] CSR_MCAUSE  = 12'h342;
  localparam logic [CSR_AW-1:0] CSR_MTVAL   = 12'h343;

  localparam logic [XLEN-1:0] CAUSE_ILLEGAL = 32'd2;
  localparam logic [XLEN-1:0] CAUSE_ECALL_M = 32'd11;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DRAIN     = 3'd1,
    ST_W_MEPC    = 3'd2,
    ST_W_MCAUSE  = 3'd3,
    ST_W_MTVAL   = 3'd4,
    ST_W_MSTATUS = 3'd5,
    ST_REDIRECT  = 3'd6
  } trap_state_e;

  typedef enum logic [1:0] {
    EV_ILLEGAL = 2'd0,
    EV_ECALL   = 2'd1,
    EV_MRET    = 2'd2
  } trap_kind_e;

  // Payload presented on the shared CSR write port
  typedef struct packed {
    logic [CSR_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } csr_wr_t;

  function automatic logic [XLEN-1:0] align4(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/trap_ctrl_mstatus_update.sv
// Computes the mstatus value written on trap entry or on mret.
module mstatus_update
  import trap_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] mstatus,
  input  logic            is_mret,
  output logic [XLEN-1:0] mstatus_new_c
);

  always_comb begin
    mstatus_new_c = mstatus;
    mstatus_new_c[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    if (is_mret) begin
      mstatus_new_c[MSTATUS_MIE]  = mstatus[MSTATUS_MPIE];
      mstatus_new_c[MSTATUS_MPIE] = 1'b1;
    end else begin
      mstatus_new_c[MSTATUS_MPIE] = mstatus[MSTATUS_MIE];
      mstatus_new_c[MSTATUS_MIE]  = 1'b0;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Multi-cycle trap/mret sequencer: freezes ID, drains the pipe, writes the
// machine CSRs through the shared port, then redirects the PC.
module trap_ctrl
  import trap_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              is_illegal_ir,
  input  logic              is_ecall,
  input  logic              is_mret,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_ir,
  input  logic              pipe_empty,
  input  logic [XLEN-1:0]   mtvec,
  input  logic [XLEN-1:0]   mepc,
  input  logic [XLEN-1:0]   mstatus,
  output logic              csr_req,
  output logic [CSR_AW-1:0] csr_addr,
  output logic [XLEN-1:0]   csr_wdata,
  input  logic              csr_ack,
  output logic              stall_id,
  output logic              flush_if,
  output logic              redirect,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              busy
);

  trap_state_e     state_q, state_d;
  trap_kind_e      kind_q, kind_d;
  logic [XLEN-1:0] pc_q, ir_q;

  csr_wr_t         csr_q, csr_d;
  logic            csr_req_q, csr_req_d;
  logic            redirect_q, redirect_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            stall_q, stall_d;
  logic            flush_q, flush_d;
  logic            busy_q, busy_d;

  logic            event_c;
  logic            accept_c;
  logic            is_mret_q;
  logic [XLEN-1:0] mstatus_new_c;

  assign event_c   = id_valid & (is_illegal_ir | is_ecall | is_mret);
  assign accept_c  = (state_q == ST_IDLE) & event_c;
  assign is_mret_q = (kind_q == EV_MRET);

  // Event priority: illegal > ecall > mret
  always_comb begin
    kind_d = EV_MRET;
    if (is_illegal_ir)  kind_d = EV_ILLEGAL;
    else if (is_ecall)  kind_d = EV_ECALL;
  end

  mstatus_update u_mstatus_update (
    .mstatus       (mstatus),
    .is_mret       (is_mret_q),
    .mstatus_new_c (mstatus_new_c)
  );

  // State register and event capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      kind_q  <= EV_ILLEGAL;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept_c) begin
        kind_q <= kind_d;
        pc_q   <= id_pc;
        ir_q   <= id_ir;
      end
    end
  end

  // Next state, plus the registered-output values for that next state
  always_comb begin
    state_d       = state_q;
    csr_req_d     = 1'b0;
    csr_d         = '0;
    redirect_d    = 1'b0;
    redirect_pc_d = '0;

    unique case (state_q)
      ST_IDLE:      if (event_c) state_d = ST_DRAIN;
      ST_DRAIN:     if (pipe_empty) state_d = is_mret_q ? ST_W_MSTATUS : ST_W_MEPC;
      ST_W_MEPC:    if (csr_ack) state_d = ST_W_MCAUSE;
      ST_W_MCAUSE:  if (csr_ack) state_d = ST_W_MTVAL;
      ST_W_MTVAL:   if (csr_ack) state_d = ST_W_MSTATUS;
      ST_W_MSTATUS: if (csr_ack) state_d = ST_REDIRECT;
      ST_REDIRECT:  state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase

    unique case (state_d)
      ST_W_MEPC: begin
        csr_req_d  = 1'b1;
        csr_d.addr = CSR_MEPC;
        csr_d.data = align4(pc_q);
      end
      ST_W_MCAUSE: begin
        csr_req_d  = 1'b1;
        csr_d.addr = CSR_MCAUSE;
        csr_d.data = (kind_q == EV_ILLEGAL) ? CAUSE_ILLEGAL : CAUSE_ECALL_M;
      end
      ST_W_MTVAL: begin
        csr_req_d  = 1'b1;
        csr_d.addr = CSR_MTVAL;
        csr_d.data = (kind_q == EV_ILLEGAL) ? ir_q : '0;
      end
      ST_W_MSTATUS: begin
        // mstatus is a live input: freeze the value taken on entry until acked
        csr_req_d  = 1'b1;
        csr_d.addr = CSR_MSTATUS;
        csr_d.data = (state_q == ST_W_MSTATUS) ? csr_q.data : mstatus_new_c;
      end
      ST_REDIRECT: begin
        // Sampled after the mepc write has retired; only direct-mode mtvec
        redirect_d    = 1'b1;
        redirect_pc_d = is_mret_q ? align4(mepc) : align4(mtvec);
      end
      default: ;
    endcase

    busy_d  = (state_d != ST_IDLE);
    stall_d = (state_d != ST_IDLE);
    flush_d = (state_d == ST_REDIRECT);
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      csr_req_q     <= 1'b0;
      csr_q         <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      stall_q       <= 1'b0;
      flush_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      csr_req_q     <= csr_req_d;
      csr_q         <= csr_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      stall_q       <= stall_d;
      flush_q       <= flush_d;
      busy_q        <= busy_d;
    end
  end

  assign csr_req     = csr_req_q;
  assign csr_addr    = csr_q.addr;
  assign csr_wdata   = csr_q.data;
  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign busy        = busy_q;
  // ID freezes and IF/ID is killed already in the cycle that accepts the event
  assign stall_id    = stall_q | accept_c;
  assign flush_if    = flush_q | accept_c;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: stimulus queues expected CSR writes and
// redirects; a monitor pops and compares them as the DUT produces them.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, is_illegal_ir, is_ecall, is_mret;
  logic [31:0] id_pc, id_ir;
  logic        pipe_empty;
  logic [31:0] mtvec, mepc, mstatus;
  logic        csr_req;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_ack;
  logic        stall_id, flush_if, redirect, busy;
  logic [31:0] redirect_pc;

  trap_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .is_illegal_ir(is_illegal_ir),
    .is_ecall(is_ecall), .is_mret(is_mret), .id_pc(id_pc), .id_ir(id_ir),
    .pipe_empty(pipe_empty), .mtvec(mtvec), .mepc(mepc), .mstatus(mstatus),
    .csr_req(csr_req), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_ack(csr_ack), .stall_id(stall_id), .flush_if(flush_if),
    .redirect(redirect), .redirect_pc(redirect_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_redir;
    logic [11:0] addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  logic [11:0] delay_addr   = 12'hFFF;
  int          delay_n      = 0;
  bit          spurious_ack = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic exp_csr(input logic [11:0] a, input logic [31:0] d);
    exp_t e;
    e.is_redir = 1'b0; e.addr = a; e.data = d; e.cyc = -1;
    exp_q.push_back(e);
  endtask

  task automatic exp_redir(input logic [31:0] pc, input int at);
    exp_t e;
    e.is_redir = 1'b1; e.addr = '0; e.data = pc; e.cyc = at;
    exp_q.push_back(e);
  endtask

  // CSR-file model: acks every request, optionally holding one address off
  initial begin
    int hold;
    hold    = 0;
    csr_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (csr_req === 1'b1) begin
        if (csr_addr == delay_addr && hold < delay_n) begin
          csr_ack = 1'b0;
          hold++;
        end else csr_ack = 1'b1;
      end else begin
        csr_ack = spurious_ack;
        hold    = 0;
      end
    end
  end

  // Monitor: compares every accepted CSR write and every redirect
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0) begin
      if (csr_req === 1'b1 && csr_ack === 1'b1) begin
        if (exp_q.size() == 0) check(1'b0, "unexpected_csr_write", {20'h0, csr_addr}, 32'h0);
        else begin
          e = exp_q.pop_front();
          check(!e.is_redir && csr_addr == e.addr, "csr_addr", {20'h0, csr_addr}, {20'h0, e.addr});
          check(csr_wdata == e.data, "csr_wdata", csr_wdata, e.data);
        end
      end else if (csr_req === 1'b1 && exp_q.size() > 0 && !exp_q[0].is_redir) begin
        check(csr_addr == exp_q[0].addr, "csr_addr_hold", {20'h0, csr_addr}, {20'h0, exp_q[0].addr});
        check(csr_wdata == exp_q[0].data, "csr_wdata_hold", csr_wdata, exp_q[0].data);
      end
      if (redirect === 1'b1) begin
        if (exp_q.size() == 0) check(1'b0, "unexpected_redirect", redirect_pc, 32'h0);
        else begin
          e = exp_q.pop_front();
          check(e.is_redir && redirect_pc == e.data, "redirect_pc", redirect_pc, e.data);
          if (e.cyc >= 0) check(cyc == e.cyc, "redirect_cycle", cyc, e.cyc);
          check(stall_id && flush_if && busy, "redirect_stall_flush_busy",
                {29'h0, stall_id, flush_if, busy}, 32'h7);
        end
      end
    end
  end

  task automatic check_all_zero(input string name);
    check({csr_req, redirect, busy, stall_id, flush_if} == 5'b0, name,
          {27'h0, csr_req, redirect, busy, stall_id, flush_if}, 32'h0);
    check(csr_addr == 12'h0 && csr_wdata == 32'h0 && redirect_pc == 32'h0,
          {name, "_data"}, csr_wdata | redirect_pc | {20'h0, csr_addr}, 32'h0);
  endtask

  // Presents one event for a single cycle; optionally holds pipe_empty low
  task automatic issue(input bit ill, input bit ec, input bit mr,
                       input logic [31:0] pc, input logic [31:0] ir,
                       input int drain, output int acc);
    @(posedge clk); #1;
    id_valid = 1'b1; is_illegal_ir = ill; is_ecall = ec; is_mret = mr;
    id_pc = pc; id_ir = ir;
    if (drain > 0) pipe_empty = 1'b0;
    acc = cyc;
    #1;
    check(stall_id && flush_if && !busy, "accept_cycle_outputs",
          {29'h0, stall_id, flush_if, busy}, 32'h6);
    @(posedge clk); #1;
    id_valid = 1'b0; is_illegal_ir = 1'b0; is_ecall = 1'b0; is_mret = 1'b0;
    if (drain > 0) begin
      repeat (drain) @(posedge clk);
      #1 pipe_empty = 1'b1;
    end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      check(1'b0, {name, "_timeout"}, exp_q.size(), 32'h0);
      exp_q.delete();
    end
  endtask

  initial begin
    int acc;
    int n;
    rst = 1'b1; id_valid = 1'b0; is_illegal_ir = 1'b0; is_ecall = 1'b0; is_mret = 1'b0;
    id_pc = '0; id_ir = '0; pipe_empty = 1'b1;
    mtvec = 32'h801; mepc = 32'h0; mstatus = 32'h8;
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset_state");
    rst = 1'b0;

    // Illegal instruction, minimum latency
    issue(1, 0, 0, 32'h100, 32'hFFFF_FFFF, 0, acc);
    exp_csr(12'h341, 32'h100); exp_csr(12'h342, 32'd2);
    exp_csr(12'h343, 32'hFFFF_FFFF); exp_csr(12'h300, 32'h1880);
    exp_redir(32'h800, acc + 6);
    wait_done("illegal");

    // ecall with a 3-cycle drain and stray acks while nothing is requested
    mstatus = 32'h1888; spurious_ack = 1'b1;
    issue(0, 1, 0, 32'h206, 32'h0000_0073, 3, acc);
    spurious_ack = 1'b0;
    exp_csr(12'h341, 32'h204); exp_csr(12'h342, 32'd11);
    exp_csr(12'h343, 32'h0); exp_csr(12'h300, 32'h1880);
    exp_redir(32'h800, acc + 9);
    wait_done("ecall_drain");

    // mret, then an ecall accepted in the first IDLE cycle after REDIRECT
    mepc = 32'h2004; mstatus = 32'h80;
    issue(0, 0, 1, 32'h3000, 32'h3020_0073, 0, acc);
    exp_csr(12'h300, 32'h1888);
    exp_redir(32'h2004, acc + 3);
    n = 0;
    do begin @(negedge clk); n++; end while (redirect !== 1'b1 && n < 20);
    check(n < 20, "mret_redirect_seen", n, 32'd20);
    issue(0, 1, 0, 32'h300, 32'h0000_0073, 0, acc);
    exp_csr(12'h341, 32'h300); exp_csr(12'h342, 32'd11);
    exp_csr(12'h343, 32'h0); exp_csr(12'h300, 32'h1800);
    exp_redir(32'h800, acc + 6);
    wait_done("back_to_back");

    // mcause ack held off for 2 cycles
    mstatus = 32'h0; delay_addr = 12'h342; delay_n = 2;
    issue(1, 0, 0, 32'h400, 32'h1234_5678, 0, acc);
    exp_csr(12'h341, 32'h400); exp_csr(12'h342, 32'd2);
    exp_csr(12'h343, 32'h1234_5678); exp_csr(12'h300, 32'h1800);
    exp_redir(32'h800, acc + 8);
    wait_done("delayed_ack");

    // Reset while waiting in W_MTVAL
    delay_addr = 12'h343; delay_n = 1000;
    issue(0, 1, 0, 32'h500, 32'h0000_0073, 0, acc);
    exp_csr(12'h341, 32'h500); exp_csr(12'h342, 32'd11); exp_csr(12'h343, 32'h0);
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(csr_req === 1'b1 && csr_addr == 12'h343) && n < 20);
    check(n < 20, "reached_w_mtval", n, 32'd20);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    check_all_zero("after_mid_reset");
    delay_addr = 12'hFFF; delay_n = 0;
    repeat (4) @(negedge clk);
    check(busy == 1'b0 && redirect == 1'b0, "idle_after_reset",
          {30'h0, busy, redirect}, 32'h0);

    // ecall after the reset sequences normally
    mstatus = 32'h8;
    issue(0, 1, 0, 32'h600, 32'h0000_0073, 0, acc);
    exp_csr(12'h341, 32'h600); exp_csr(12'h342, 32'd11);
    exp_csr(12'h343, 32'h0); exp_csr(12'h300, 32'h1880);
    exp_redir(32'h800, acc + 6);
    wait_done("ecall_after_reset");

    // Illegal and ecall together: illegal wins
    issue(1, 1, 0, 32'h700, 32'hDEAD_BEEF, 0, acc);
    exp_csr(12'h341, 32'h700); exp_csr(12'h342, 32'd2);
    exp_csr(12'h343, 32'hDEAD_BEEF); exp_csr(12'h300, 32'h1880);
    exp_redir(32'h800, acc + 6);
    wait_done("illegal_ecall_priority");

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Multi-cycle trap sequencer for the decode stage. It takes the illegal-instruction, ecall and mret flags produced by ID decode control and freezes ID. It drains older instructions from the pipeline, then performs the machine-mode CSR updates through the shared CSR write port. Finally it redirects the PC to `mtvec` (trap) or `mepc` (mret).

## Interface
Parameters: none.

Clock and reset: one clock; reset is synchronous and active-high.

- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `id_valid`  in  1  ID holds a valid instruction this cycle
- `is_illegal_ir`  in  1  ID instruction is illegal
- `is_ecall`  in  1  ID instruction is ecall
- `is_mret`  in  1  ID instruction is mret
- `id_pc`  in  32  PC of the ID instruction
- `id_ir`  in  32  raw ID instruction
- `pipe_empty`  in  1  EX/MEM/WB hold no valid instruction
- `mtvec`  in  32  current mtvec
- `mepc`  in  32  current mepc
- `mstatus`  in  32  current mstatus
- `csr_req`  out  1  request on the shared CSR write port
- `csr_addr`  out  12  CSR address being written
- `csr_wdata`  out  32  write data
- `csr_ack`  in  1  CSR file accepted the write this cycle
- `stall_id`  out  1  hold PC and IF/ID
- `flush_if`  out  1  kill the IF/ID instruction younger than the trapping one
- `redirect`  out  1  one-cycle PC redirect strobe
- `redirect_pc`  out  32  redirect target
- `busy`  out  1  FSM not in IDLE

## Operation
- **Event priority in IDLE:** illegal > ecall > mret. An event requires `id_valid`.
- **On an event**, capture `id_pc`, `id_ir` and the event kind into registers. Inputs are ignored until the FSM returns to IDLE.
- **States:** IDLE, DRAIN, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS, REDIRECT.
- **Trap path:** IDLE → DRAIN → W_MEPC → W_MCAUSE → W_MTVAL → W_MSTATUS → REDIRECT → IDLE.
- **mret path:** IDLE → DRAIN → W_MSTATUS → REDIRECT → IDLE.
- **DRAIN:** hold while `pipe_empty`=0.
- **W_\* states:**
  - `csr_req`=1 with the state's address and data, held stable until `csr_ack`.
  - Advance on the cycle after ack is sampled.
- **CSR write data:**
  - W_MEPC: address 0x341, data `{pc_q[31:2],2'b00}`.
  - W_MCAUSE: address 0x342, data 2 (illegal) or 11 (ecall from M).
  - W_MTVAL: address 0x343, data `ir_q` (illegal) or 0 (ecall).
  - W_MSTATUS (trap): address 0x300, data = `mstatus` with MPIE[7]←MIE[3], MIE[3]←0, MPP[12:11]←2'b11.
  - W_MSTATUS (mret): address 0x300, data = `mstatus` with MIE[3]←MPIE[7], MPIE[7]←1, MPP←2'b11.
- **REDIRECT:** `redirect`=1 with `redirect_pc` = `{mtvec[31:2],2'b00}` (trap, direct mode only) or `{mepc[31:2],2'b00}` (mret).
  - The value used is the one sampled in REDIRECT, so the just-written `mepc` is used.
- **ID decode control** already suppresses `wr_reg_n`/`wr_csr_n` for illegal instructions. This block never writes the register file.

## Timing
- **Reset:** all outputs 0 and state IDLE on the cycle after `rst`=1. This includes reset mid-sequence: any pending `csr_req` drops and no redirect is issued.
- **All outputs are decoded from registered state only.** No input-to-output combinational path exists, except `stall_id`/`flush_if`, which also assert combinationally in the IDLE cycle that accepts an event.
- **`stall_id`** =1 from the acceptance cycle through REDIRECT inclusive.
- **`flush_if`** =1 in the acceptance cycle and in REDIRECT.
- **`busy`** =1 in every state except IDLE.
- **Minimum latency** (event at cycle 0, `pipe_empty`=1, `csr_ack` same-cycle):
  - trap: REDIRECT at cycle 6.
  - mret: REDIRECT at cycle 3.
- **Back-to-back:** a new event can be accepted in the first IDLE cycle after REDIRECT.
- **Acks:** a `csr_ack` without `csr_req` is ignored.

## Structure
- Shared constants files (same style as the other decode constants) hold:
  - CSR addresses (0x300, 0x305, 0x341, 0x342, 0x343);
  - trap cause codes (ILLEGAL=2, ECALL_M=11);
  - FSM state encodings.
- One combinational sub-module, `mstatus_update`: inputs `mstatus` and the trap/mret select; output the new mstatus value.
- Everything else is in `trap_ctrl`.

## Test plan
- **Illegal instruction**, `id_pc`=0x100, `id_ir`=0xFFFFFFFF, `mtvec`=0x801, `pipe_empty`=1, immediate acks:
  - CSR writes in order: 0x341←0x100, 0x342←2, 0x343←0xFFFFFFFF, 0x300 (MIE cleared).
  - `redirect_pc`=0x800 at cycle 6.
- **ecall** with `pipe_empty` low for 3 cycles: DRAIN is held 3 cycles; mcause=11, mtval=0; redirect arrives 3 cycles later than minimum.
- **mret** with `mepc`=0x2004, `mstatus`=0x80: only 0x300 is written, with MIE=1, MPIE=1; `redirect_pc`=0x2004 at cycle 3.
- **`csr_ack` delayed 2 cycles on W_MCAUSE:** address and data are held stable and no state is skipped.
- **`rst` asserted in W_MTVAL:** the next cycle has all outputs 0 and no redirect; a subsequent ecall sequences normally.
- **Simultaneous `is_illegal_ir` and `is_ecall`:** treated as illegal (mcause=2).
